sonar_driver: RTL and testbench

Responder side of the sonar measurement handshake for an HC-SR04-class ultrasonic ranger. It accepts a one-cycle `sonar_measure` request from the control unit, drives the sensor trigger pulse, and times the echo pulse. It then converts the echo width to whole centimetres and returns the result with a one-cycle `sonar_ready` pulse. It sits between the control unit and the sensor pins.

---
 rtl/sonar_pkg.sv | 26 ++
 rtl/sonar_driver_if.sv | 19 +
 rtl/sync_2ff.sv | 22 ++
 rtl/sonar_driver.sv | 155 +++++++++++++++
 tb/tb_sonar_driver.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar ranger driver: state encoding,
// timeout distance code and the microsecond-to-cycle conversion.
package sonar_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIG      = 3'd1;
    localparam logic [2:0] ST_WAIT_RISE = 3'd2;
    localparam logic [2:0] ST_MEASURE   = 3'd3;
    localparam logic [2:0] ST_HOLDOFF   = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        TRIG      = ST_TRIG,
        WAIT_RISE = ST_WAIT_RISE,
        MEASURE   = ST_MEASURE,
        HOLDOFF   = ST_HOLDOFF
    } state_t;

    localparam logic [7:0] TIMEOUT_DIST = 8'hFF;

    function automatic int unsigned us_to_cycles(input int unsigned us,
                                                 input int unsigned clk_mhz);
        return us * clk_mhz;
    endfunction

endpackage

// File: rtl/sonar_driver_if.sv
// Control-unit side of the sonar measurement handshake: request in,
// range result, timeout flag and busy status out.
interface sonar_driver_if;
    logic       sonar_measure;
    logic       sonar_ready;
    logic       sonar_timeout;
    logic [7:0] sonar_distance;
    logic       busy;

    modport master (
        output sonar_measure,
        input  sonar_ready, sonar_timeout, sonar_distance, busy
    );

    modport slave (
        input  sonar_measure,
        output sonar_ready, sonar_timeout, sonar_distance, busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/sonar_driver.sv
// HC-SR04-style ranger driver: fires the trigger pulse, times the echo and
// returns the range in whole centimetres (saturating) or a timeout code.
module sonar_driver
    import sonar_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ = 50,
    parameter int unsigned TRIG_US      = 10,
    parameter int unsigned TIMEOUT_US   = 30000,
    parameter int unsigned HOLDOFF_US   = 60000,
    parameter int unsigned US_PER_CM    = 58
) (
    input  logic          clk,
    input  logic          rst_n,
    sonar_driver_if.slave bus,
    input  logic          echo,
    output logic          trig
);
    localparam int unsigned TRIG_CYC = us_to_cycles(TRIG_US, CLK_FREQ_MHZ);
    localparam int unsigned TO_CYC   = us_to_cycles(TIMEOUT_US, CLK_FREQ_MHZ);
    localparam int unsigned HOLD_CYC = us_to_cycles(HOLDOFF_US, CLK_FREQ_MHZ);
    localparam int unsigned CM_CYC   = us_to_cycles(US_PER_CM, CLK_FREQ_MHZ);
    localparam int unsigned PH_MAX   = (TRIG_CYC > HOLD_CYC) ? TRIG_CYC : HOLD_CYC;

    localparam int PH_W  = $clog2(PH_MAX + 1);
    localparam int TO_W  = $clog2(TO_CYC + 1);
    localparam int SUB_W = $clog2(CM_CYC + 1);

    localparam logic [PH_W-1:0]  TRIG_END  = PH_W'(TRIG_CYC);
    // The IDLE cycle and the registered trigger add two cycles, so the
    // HOLDOFF state is shortened to make result-to-trigger exactly HOLD_CYC.
    localparam logic [PH_W-1:0]  HOLD_LAST = PH_W'((HOLD_CYC > 3) ? HOLD_CYC - 3 : 0);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CM_CYC - 1);
    // The rise-detect cycle is itself the first cycle of echo width.
    localparam logic [SUB_W-1:0] SUB_START = SUB_W'((CM_CYC > 1) ? 1 : 0);
    localparam logic [7:0]       CM_START  = 8'((CM_CYC > 1) ? 0 : 1);

    state_t           state_q;
    logic             trig_q;
    logic             ready_q;
    logic             timeout_q;
    logic             busy_q;
    logic             pending_q;
    logic [7:0]       dist_q;
    logic [7:0]       cm_q;
    logic [PH_W-1:0]  ph_q;
    logic [TO_W-1:0]  to_q;
    logic [SUB_W-1:0] sub_q;

    logic echo_sync;
    logic echo_prev_q;
    logic echo_rise;
    logic echo_fall;

    sync_2ff u_echo_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (echo),
        .q_o   (echo_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) echo_prev_q <= 1'b0;
        else        echo_prev_q <= echo_sync;
    end

    assign echo_rise = echo_sync & ~echo_prev_q;
    assign echo_fall = ~echo_sync & echo_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            trig_q    <= 1'b0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
            dist_q    <= '0;
            cm_q      <= '0;
            ph_q      <= '0;
            to_q      <= '0;
            sub_q     <= '0;
        end else begin
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= (state_q != IDLE);
            if (bus.sonar_measure && state_q != IDLE) pending_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (bus.sonar_measure || pending_q) begin
                        pending_q <= 1'b0;
                        ph_q      <= '0;
                        state_q   <= TRIG;
                    end
                end
                TRIG: begin
                    if (ph_q == TRIG_END) begin
                        trig_q  <= 1'b0;
                        to_q    <= '0;
                        state_q <= WAIT_RISE;
                    end else begin
                        trig_q <= 1'b1;
                        ph_q   <= ph_q + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    to_q <= to_q + 1'b1;
                    if (to_q == TO_LAST) begin
                        dist_q    <= TIMEOUT_DIST;
                        ready_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        ph_q      <= '0;
                        state_q   <= HOLDOFF;
                    end else if (echo_rise) begin
                        sub_q   <= SUB_START;
                        cm_q    <= CM_START;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    to_q <= to_q + 1'b1;
                    if (echo_fall) begin
                        dist_q  <= cm_q;
                        ready_q <= 1'b1;
                        ph_q    <= '0;
                        state_q <= HOLDOFF;
                    end else if (to_q == TO_LAST) begin
                        dist_q    <= TIMEOUT_DIST;
                        ready_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        ph_q      <= '0;
                        state_q   <= HOLDOFF;
                    end else if (sub_q == SUB_LAST) begin
                        sub_q <= '0;
                        if (cm_q != 8'hFF) cm_q <= cm_q + 8'd1;
                    end else begin
                        sub_q <= sub_q + 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (ph_q == HOLD_LAST) state_q <= IDLE;
                    else                   ph_q    <= ph_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign trig               = trig_q;
    assign bus.sonar_ready    = ready_q;
    assign bus.sonar_timeout  = timeout_q;
    assign bus.sonar_distance = dist_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_sonar_driver.sv
// Directed bench for sonar_driver at 1 MHz: trigger width, echo-to-cm
// conversion, saturation, timeouts, request collapsing and mid-run reset.
module tb_sonar_driver;
    logic clk;
    logic rst_n;
    logic echo;
    logic trig;
    int   n_assert;
    int   n_fail;

    sonar_driver_if bus ();

    sonar_driver #(
        .CLK_FREQ_MHZ (1),
        .TRIG_US      (10),
        .TIMEOUT_US   (30000),
        .HOLDOFF_US   (100),
        .US_PER_CM    (58)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .echo  (echo),
        .trig  (trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Entered at the first sample with trig high; leaves at the sample after trig falls.
    task automatic trig_width(input string tag);
        int cnt;
        cnt = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (trig === 1'b1) cnt++;
            else break;
        end
        check({tag, "_trig_width"}, 32'(cnt), 32'd10);
    endtask

    task automatic launch(input string tag);
        bus.sonar_measure = 1'b1;
        tick();
        bus.sonar_measure = 1'b0;
        check({tag, "_trig_pre"}, 32'(trig), 32'd0);
        tick();
        check({tag, "_trig_rise"}, 32'(trig), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        trig_width(tag);
    endtask

    task automatic echo_pulse(input int delay, input int width);
        repeat (delay) tick();
        echo = 1'b1;
        repeat (width) tick();
        echo = 1'b0;
    endtask

    task automatic wait_ready(input int limit, output int waited);
        waited = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (bus.sonar_ready === 1'b1) begin
                waited = i;
                break;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bus.sonar_ready === 1'b1) n++;
            if (bus.busy === 1'b0) break;
        end
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_extra_ready"}, 32'(n), 32'd0);
    endtask

    task automatic result_check(input string tag, input logic [7:0] exp_d, input logic exp_to);
        check({tag, "_dist"}, 32'(bus.sonar_distance), 32'(exp_d));
        check({tag, "_timeout"}, 32'(bus.sonar_timeout), 32'(exp_to));
        $display("result %s: ready=%0d distance=%0d timeout=%0d",
                 tag, bus.sonar_ready, bus.sonar_distance, bus.sonar_timeout);
        tick();
        check({tag, "_ready_1cyc"}, 32'(bus.sonar_ready), 32'd0);
        check({tag, "_timeout_1cyc"}, 32'(bus.sonar_timeout), 32'd0);
    endtask

    task automatic measure(input string tag, input int width, input logic [7:0] exp_d);
        int w;
        launch(tag);
        echo_pulse(3, width);
        wait_ready(20, w);
        check({tag, "_ready_lat"}, 32'(w), 32'd3);
        result_check(tag, exp_d, 1'b0);
        drain(tag);
        check({tag, "_held"}, 32'(bus.sonar_distance), 32'(exp_d));
    endtask

    initial begin
        int w;
        int t;
        int n;
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        echo  = 1'b0;
        bus.sonar_measure = 1'b0;
        repeat (3) tick();
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_ready", 32'(bus.sonar_ready), 32'd0);
        check("rst_timeout", 32'(bus.sonar_timeout), 32'd0);
        check("rst_dist", 32'(bus.sonar_distance), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        measure("m580", 580, 8'd10);
        measure("m14790", 14790, 8'd255);
        measure("m15080_sat", 15080, 8'd255);

        // No echo at all: timeout exactly 30000 cycles after trig falls.
        launch("noecho");
        wait_ready(30100, w);
        check("noecho_ready_at", 32'(w), 32'd30000);
        result_check("noecho", 8'hFF, 1'b1);
        drain("noecho");

        // Echo stuck high past the limit; its late fall must be ignored.
        launch("stuck");
        echo_pulse(3, 0);
        echo = 1'b1;
        wait_ready(30100, w);
        check("stuck_ready_at", 32'(w + 3), 32'd30000);
        result_check("stuck", 8'hFF, 1'b1);
        echo = 1'b0;
        drain("stuck");
        check("stuck_held", 32'(bus.sonar_distance), 32'hFF);

        // Three requests during MEASURE collapse into one extra trigger.
        launch("pend");
        repeat (3) tick();
        echo = 1'b1;
        for (int i = 0; i < 580; i++) begin
            bus.sonar_measure = (i == 100 || i == 200 || i == 300);
            tick();
        end
        bus.sonar_measure = 1'b0;
        echo = 1'b0;
        wait_ready(20, w);
        check("pend_ready_lat", 32'(w), 32'd3);
        result_check("pend", 8'd10, 1'b0);
        t = 1;
        for (int i = 0; i < 300; i++) begin
            if (trig === 1'b1) break;
            tick();
            t++;
        end
        check("pend_retrig_at", 32'(t), 32'd100);
        trig_width("pend2");
        echo_pulse(3, 580);
        wait_ready(20, w);
        check("pend2_ready_lat", 32'(w), 32'd3);
        result_check("pend2", 8'd10, 1'b0);
        drain("pend2");
        n = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (trig === 1'b1) n++;
        end
        check("pend_no_third_trig", 32'(n), 32'd0);

        // Request exactly on the HOLDOFF->IDLE edge is kept and serviced.
        launch("hedge");
        echo_pulse(3, 637);
        wait_ready(20, w);
        check("hedge_ready_lat", 32'(w), 32'd3);
        check("hedge_dist", 32'(bus.sonar_distance), 32'd10);
        repeat (97) tick();
        bus.sonar_measure = 1'b1;
        tick();
        bus.sonar_measure = 1'b0;
        t = 98;
        for (int i = 0; i < 300; i++) begin
            tick();
            t++;
            if (trig === 1'b1) break;
        end
        check("hedge_retrig_at", 32'(t), 32'd100);
        trig_width("hedge2");
        echo_pulse(3, 580);
        wait_ready(20, w);
        check("hedge2_ready_lat", 32'(w), 32'd3);
        result_check("hedge2", 8'd10, 1'b0);
        drain("hedge2");

        // Reset asserted while the trigger is high.
        bus.sonar_measure = 1'b1;
        tick();
        bus.sonar_measure = 1'b0;
        repeat (3) tick();
        check("rtrig_trig_before", 32'(trig), 32'd1);
        rst_n = 1'b0;
        #2;
        check("rtrig_trig", 32'(trig), 32'd0);
        check("rtrig_ready", 32'(bus.sonar_ready), 32'd0);
        check("rtrig_dist", 32'(bus.sonar_distance), 32'd0);
        check("rtrig_busy", 32'(bus.busy), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.sonar_ready === 1'b1 || trig === 1'b1) n++;
        end
        check("rtrig_quiet", 32'(n), 32'd0);
        measure("rtrig_after", 580, 8'd10);

        // Reset asserted in the middle of an echo.
        launch("rmeas");
        repeat (3) tick();
        echo = 1'b1;
        repeat (100) tick();
        rst_n = 1'b0;
        #2;
        check("rmeas_trig", 32'(trig), 32'd0);
        check("rmeas_dist", 32'(bus.sonar_distance), 32'd0);
        check("rmeas_busy", 32'(bus.busy), 32'd0);
        repeat (2) tick();
        echo = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.sonar_ready === 1'b1) n++;
        end
        check("rmeas_no_ready", 32'(n), 32'd0);
        measure("rmeas_after", 580, 8'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
